key_scan: RTL

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/key_scan.sv
// key_scan: four-key front-panel scanner.
// Each raw active-low key is synchronised, debounced by its own FSM and
// classified as a short or long press. Press events are held in per-key
// pending slots, arbitrated lowest-index-first into a 4-deep event FIFO,
// and popped by rising edges of the ARM acknowledge line.

module key_scan #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] KEY_IN,
    input  logic       ARM_KEY_ACK,
    output logic [3:0] KEY_STATE,
    output logic [2:0] KEY_CODE,
    output logic       KEY_IRQ,
    output logic       KEY_OVF
);

    localparam int NUM_KEYS   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int DW = ($clog2(DEBOUNCE_CYCLES + 1) > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int HW = ($clog2(LONG_CYCLES + 1) > 0) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LIMIT  = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(LONG_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        LONG_HELD,
        RELEASE_DEB
    } key_fsm_t;

    // Saturating increments: the counters stop at their limit and never wrap.
    function automatic logic [DW-1:0] deb_inc(input logic [DW-1:0] c);
        return (c >= DEB_LIMIT) ? DEB_LIMIT : c + 1'b1;
    endfunction

    function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] c);
        return (c >= HOLD_LIMIT) ? HOLD_LIMIT : c + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [3:0] key_meta;
    logic [3:0] key_sync;
    logic       ack_meta;
    logic       ack_sync;
    logic       ack_dly;
    logic       ack_rise;

    // Two-flop synchronisers; keys reset to released so nothing fires at reset exit.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_meta <= '1;
            key_sync <= '1;
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
            ack_dly  <= 1'b0;
        end else begin
            key_meta <= KEY_IN;
            key_sync <= key_meta;
            ack_meta <= ARM_KEY_ACK;
            ack_sync <= ack_meta;
            ack_dly  <= ack_sync;
        end
    end

    assign ack_rise = ack_sync & ~ack_dly;

    // ------------------------------------------------------------------
    // Per-key debounce / hold FSMs
    // ------------------------------------------------------------------
    key_fsm_t      state      [NUM_KEYS];
    key_fsm_t      state_next [NUM_KEYS];
    logic [DW-1:0] deb_cnt    [NUM_KEYS];
    logic [DW-1:0] deb_next   [NUM_KEYS];
    logic [HW-1:0] hold_cnt   [NUM_KEYS];
    logic [HW-1:0] hold_next  [NUM_KEYS];
    logic [3:0]    post_valid;
    logic [3:0]    post_long;

    // Key FSM state and counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i]    <= IDLE;
                deb_cnt[i]  <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i]    <= state_next[i];
                deb_cnt[i]  <= deb_next[i];
                hold_cnt[i] <= hold_next[i];
            end
        end
    end

    // Next-state logic: debounce presses/releases, time the hold, post events.
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        post_valid = '0;
        post_long  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_next[i] = state[i];
            deb_next[i]   = deb_cnt[i];
            hold_next[i]  = hold_cnt[i];

            unique case (state[i])
                IDLE, PRESS_DEB: begin
                    if (!key_sync[i]) begin
                        if (deb_inc(deb_cnt[i]) >= DEB_LIMIT) begin
                            state_next[i] = HELD;
                            deb_next[i]   = '0;
                            hold_next[i]  = '0;
                        end else begin
                            state_next[i] = PRESS_DEB;
                            deb_next[i]   = deb_inc(deb_cnt[i]);
                        end
                    end else begin
                        state_next[i] = IDLE;
                        deb_next[i]   = '0;
                    end
                end

                HELD, LONG_HELD, RELEASE_DEB: begin
                    if (!key_sync[i]) begin
                        deb_next[i] = '0;
                        if (state[i] == RELEASE_DEB) begin
                            // A bounce during release: resume whichever held state we came from.
                            state_next[i] = (hold_cnt[i] >= HOLD_LIMIT) ? LONG_HELD : HELD;
                        end else if (state[i] == HELD) begin
                            hold_next[i] = hold_inc(hold_cnt[i]);
                            if (hold_inc(hold_cnt[i]) >= HOLD_LIMIT) begin
                                state_next[i] = LONG_HELD;
                                post_valid[i] = 1'b1;
                                post_long[i]  = 1'b1;
                            end
                        end
                    end else begin
                        if (deb_inc(deb_cnt[i]) >= DEB_LIMIT) begin
                            state_next[i] = IDLE;
                            deb_next[i]   = '0;
                            hold_next[i]  = '0;
                            // A long press was already reported; only short presses post here.
                            post_valid[i] = (hold_cnt[i] < HOLD_LIMIT);
                        end else begin
                            state_next[i] = RELEASE_DEB;
                            deb_next[i]   = deb_inc(deb_cnt[i]);
                        end
                    end
                end

                default: begin
                    state_next[i] = IDLE;
                    deb_next[i]   = '0;
                    hold_next[i]  = '0;
                end
            endcase
        end
    end

    // Debounced key levels.
    always_comb begin
        KEY_STATE = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            KEY_STATE[i] = (state[i] == HELD) || (state[i] == LONG_HELD) ||
                           (state[i] == RELEASE_DEB);
        end
    end

    // ------------------------------------------------------------------
    // Pending slots and arbiter
    // ------------------------------------------------------------------
    logic [3:0] pend;
    logic [3:0] pend_long;
    logic [3:0] pend_next;
    logic [3:0] pend_long_next;
    logic [3:0] overwrite;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       grant_long;

    // Lowest-index pending slot wins the single FIFO push per cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(i);
            end
        end
        grant_long = pend_long[grant_idx];
    end

    // A new post replaces a still-pending event and flags the loss.
    always_comb begin
        pend_next      = pend;
        pend_long_next = pend_long;
        overwrite      = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (grant_valid && (grant_idx == 2'(i))) begin
                pend_next[i] = 1'b0;
            end
            if (post_valid[i]) begin
                overwrite[i]      = pend_next[i];
                pend_next[i]      = 1'b1;
                pend_long_next[i] = post_long[i];
            end
        end
    end

    // Pending slot registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend      <= '0;
            pend_long <= '0;
        end else begin
            pend      <= pend_next;
            pend_long <= pend_long_next;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [2:0] fifo_mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic       drop;

    assign fifo_empty = (count == 3'd0);
    assign fifo_full  = (count == 3'(FIFO_DEPTH));
    assign pop        = ack_rise & ~fifo_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
    assign push       = grant_valid & (~fifo_full | pop);
    assign drop       = grant_valid & fifo_full & ~pop;

    // FIFO storage write port.
    // NOTE: storage has no reset; occupancy is tracked by count and KEY_CODE masks empty entries.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {grant_long, grant_idx};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            KEY_OVF <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop || (|overwrite)) begin
                KEY_OVF <= 1'b1;
            end else if (pop) begin
                KEY_OVF <= 1'b0;
            end
        end
    end

    assign KEY_IRQ  = ~fifo_empty;
    assign KEY_CODE = fifo_empty ? 3'b000 : fifo_mem[rd_ptr];

endmodule
